// File: rtl/memory_port_arbiter.sv
// rtl/memory_port_arbiter.sv - fetch/data arbiter for the single main-memory port with wait states
// Optional round-robin arbitration under ARB_ROUND_ROBIN_EN; fixed data-over-fetch priority otherwise.
module memory_port_arbiter #(
    parameter int WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_valid,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [2:0]  d_size,
    output logic        d_gnt,
    output logic        d_valid,
    output logic        d_err,
    output logic [31:0] d_rdata,
    output logic [31:0] mem_read_address,
    input  logic [31:0] mem_read_data,
    output logic [31:0] mem_write_address,
    output logic [31:0] mem_write_data,
    output logic        mem_write_enable,
    output logic [2:0]  mem_size_and_sign,
    output logic        busy
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WAIT   = 2'd1;
    localparam logic [1:0] S_ACCESS = 2'd2;

    localparam logic [3:0] LP_CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    logic [1:0]  r_state;
    logic [3:0]  r_cnt;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [2:0]  r_size;
    logic        r_we;
    logic        r_is_data;
    logic        r_if_valid;
    logic [31:0] r_if_rdata;
    logic        r_d_valid;
    logic        r_d_err;
    logic [31:0] r_d_rdata;

    logic w_grant_ok;
    logic w_sel_d;
    logic w_sel_if;
    logic w_any_gnt;
    logic w_misaligned;

    // Grants are gated by reset so every output reads 0 while rst is low.
    assign w_grant_ok = rst && (r_state == S_IDLE);

`ifdef ARB_ROUND_ROBIN_EN
    logic r_last_data;

    assign w_sel_d = d_req && (!if_req || !r_last_data);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last_data <= 1'b1;
        end else if (w_any_gnt) begin
            r_last_data <= d_gnt;
        end
    end
`else
    assign w_sel_d = d_req;
`endif

    assign w_sel_if  = if_req && !w_sel_d;
    assign d_gnt     = w_grant_ok && w_sel_d;
    assign if_gnt    = w_grant_ok && w_sel_if;
    assign w_any_gnt = d_gnt || if_gnt;

    assign w_misaligned = ((d_size[1:0] == 2'b10) && (d_addr[1:0] != 2'b00)) ||
                          ((d_size[1:0] == 2'b01) && d_addr[0]);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= 4'd0;
            r_addr     <= 32'd0;
            r_wdata    <= 32'd0;
            r_size     <= 3'd0;
            r_we       <= 1'b0;
            r_is_data  <= 1'b0;
            r_if_valid <= 1'b0;
            r_if_rdata <= 32'd0;
            r_d_valid  <= 1'b0;
            r_d_err    <= 1'b0;
            r_d_rdata  <= 32'd0;
        end else begin
            r_if_valid <= 1'b0;
            r_d_valid  <= 1'b0;
            r_d_err    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any_gnt) begin
                        r_addr    <= d_gnt ? d_addr : if_addr;
                        r_wdata   <= d_gnt ? d_wdata : 32'd0;
                        r_size    <= d_gnt ? d_size : 3'b010;
                        r_we      <= d_gnt && d_we && !w_misaligned;
                        r_is_data <= d_gnt;
                        // A misaligned data access is answered directly from IDLE.
                        if (d_gnt && w_misaligned) begin
                            r_d_valid <= 1'b1;
                            r_d_err   <= 1'b1;
                        end else if (WAIT_STATES > 0) begin
                            r_state <= S_WAIT;
                            r_cnt   <= LP_CNT_INIT;
                        end else begin
                            r_state <= S_ACCESS;
                        end
                    end
                end
                S_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= S_ACCESS;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_ACCESS: begin
                    r_state <= S_IDLE;
                    if (r_is_data) begin
                        r_d_valid <= 1'b1;
                        if (!r_we) begin
                            r_d_rdata <= mem_read_data;
                        end
                    end else begin
                        r_if_valid <= 1'b1;
                        r_if_rdata <= mem_read_data;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Address, data and size always show the latched request so memory never sees glitches.
    assign mem_read_address  = r_addr;
    assign mem_write_address = r_addr;
    assign mem_write_data    = r_wdata;
    assign mem_size_and_sign = r_size;
    assign mem_write_enable  = (r_state == S_ACCESS) && r_we;

    assign busy     = (r_state != S_IDLE);
    assign if_valid = r_if_valid;
    assign if_rdata = r_if_rdata;
    assign d_valid  = r_d_valid;
    assign d_err    = r_d_err;
    assign d_rdata  = r_d_rdata;

endmodule

// File: tb/tb_memory_port_arbiter.sv
// tb/tb_memory_port_arbiter.sv - directed vector bench for memory_port_arbiter
module tb_memory_port_arbiter;

    localparam int WS = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = 32'd0;
    logic        if_gnt;
    logic        if_valid;
    logic [31:0] if_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = 32'd0;
    logic [31:0] d_wdata = 32'd0;
    logic [2:0]  d_size = 3'd0;
    logic        d_gnt;
    logic        d_valid;
    logic        d_err;
    logic [31:0] d_rdata;
    logic [31:0] mem_read_address;
    logic [31:0] mem_read_data;
    logic [31:0] mem_write_address;
    logic [31:0] mem_write_data;
    logic        mem_write_enable;
    logic [2:0]  mem_size_and_sign;
    logic        busy;

    always #5 clk = ~clk;

    memory_port_arbiter #(.WAIT_STATES(WS)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_size(d_size),
        .d_gnt(d_gnt), .d_valid(d_valid), .d_err(d_err), .d_rdata(d_rdata),
        .mem_read_address(mem_read_address), .mem_read_data(mem_read_data),
        .mem_write_address(mem_write_address), .mem_write_data(mem_write_data),
        .mem_write_enable(mem_write_enable), .mem_size_and_sign(mem_size_and_sign),
        .busy(busy)
    );

    logic [31:0] mem [0:255];
    int wr_target = 0;

    assign mem_read_data = mem[mem_read_address[9:2]];

    always @(posedge clk) begin
        if (!rst) begin
            mem[8'h04] <= 32'h0050_0093;
            mem[8'h41] <= 32'h1122_3344;
        end else if (mem_write_enable) begin
            mem[mem_write_address[9:2]] <= mem_write_data;
            if (mem_write_address == 32'h180) wr_target <= wr_target + 1;
        end
    end

    typedef struct {
        logic        is_d;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  size;
        logic        err;
        logic [31:0] rdata;
    } vec_t;

    vec_t vecs[10];
    int checks = 0;
    int failures = 0;
    logic [31:0] exp_d_rdata = 32'd0;
    logic [31:0] exp_if_rdata = 32'd0;

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b", name, act, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        chk1({tag, "_busy"}, busy, 1'b0);
        chk1({tag, "_we"}, mem_write_enable, 1'b0);
        chk32({tag, "_raddr"}, mem_read_address, 32'd0);
        chk32({tag, "_waddr"}, mem_write_address, 32'd0);
        chk32({tag, "_wdata"}, mem_write_data, 32'd0);
        chk32({tag, "_size"}, {29'd0, mem_size_and_sign}, 32'd0);
        chk1({tag, "_d_valid"}, d_valid, 1'b0);
        chk1({tag, "_d_err"}, d_err, 1'b0);
        chk1({tag, "_if_valid"}, if_valid, 1'b0);
        chk32({tag, "_d_rdata"}, d_rdata, 32'd0);
        chk32({tag, "_if_rdata"}, if_rdata, 32'd0);
        chk1({tag, "_d_gnt"}, d_gnt, 1'b0);
        chk1({tag, "_if_gnt"}, if_gnt, 1'b0);
    endtask

    task automatic do_txn(input vec_t v);
        int n;
        logic we_seen;
        @(negedge clk);
        if (v.is_d) begin
            d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata; d_size = v.size;
        end else begin
            if_req = 1'b1; if_addr = v.addr;
        end
        #1;
        chk1("gnt_winner", v.is_d ? d_gnt : if_gnt, 1'b1);
        chk1("gnt_other", v.is_d ? if_gnt : d_gnt, 1'b0);
        if (!v.is_d || !v.we) exp_d_rdata = exp_d_rdata;
        n = v.err ? 1 : WS + 2;
        we_seen = 1'b0;
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            if (c == 1) begin
                if_req = 1'b0; d_req = 1'b0;
            end
            #1;
            if (v.err || c != WS + 1) we_seen = we_seen | mem_write_enable;
            if (v.err) begin
                chk1("err_valid", d_valid, 1'b1);
                chk1("err_flag", d_err, 1'b1);
                chk1("err_busy", busy, 1'b0);
                chk32("err_rdata_held", d_rdata, exp_d_rdata);
            end else if (c == WS + 1) begin
                chk1("acc_busy", busy, 1'b1);
                chk1("acc_we", mem_write_enable, v.we);
                chk32("acc_raddr", mem_read_address, v.addr);
                chk32("acc_waddr", mem_write_address, v.addr);
                chk32("acc_size", {29'd0, mem_size_and_sign}, {29'd0, v.is_d ? v.size : 3'b010});
                if (v.we) chk32("acc_wdata", mem_write_data, v.wdata);
            end else if (c == WS + 2) begin
                chk1("rsp_busy", busy, 1'b0);
                if (v.is_d) begin
                    if (!v.we) exp_d_rdata = v.rdata;
                    chk1("rsp_d_valid", d_valid, 1'b1);
                    chk1("rsp_d_err", d_err, 1'b0);
                    chk1("rsp_if_valid", if_valid, 1'b0);
                    chk32("rsp_d_rdata", d_rdata, exp_d_rdata);
                end else begin
                    exp_if_rdata = v.rdata;
                    chk1("rsp_if_valid", if_valid, 1'b1);
                    chk1("rsp_d_valid", d_valid, 1'b0);
                    chk32("rsp_if_rdata", if_rdata, exp_if_rdata);
                end
            end else begin
                chk1("wait_no_valid", d_valid | if_valid, 1'b0);
            end
        end
        chk1("no_stray_we", we_seen, 1'b0);
    endtask

    initial begin
        logic [2:0] arb_exp;
        int grants;
        int cyc;
        int last_g;
        logic seen;

        vecs[0] = '{1'b0, 1'b0, 32'h10,  32'h0,         3'b010, 1'b0, 32'h0050_0093};
        vecs[1] = '{1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, 3'b010, 1'b0, 32'h0};
        vecs[2] = '{1'b1, 1'b0, 32'h100, 32'h0,         3'b010, 1'b0, 32'hDEAD_BEEF};
        vecs[3] = '{1'b1, 1'b0, 32'h102, 32'h0,         3'b010, 1'b1, 32'h0};
        vecs[4] = '{1'b1, 1'b1, 32'h203, 32'h1234,      3'b001, 1'b1, 32'h0};
        vecs[5] = '{1'b1, 1'b1, 32'h202, 32'h0000_ABCD, 3'b001, 1'b0, 32'h0};
        vecs[6] = '{1'b0, 1'b0, 32'h104, 32'h0,         3'b010, 1'b0, 32'h1122_3344};
        vecs[7] = '{1'b1, 1'b0, 32'h101, 32'h0,         3'b000, 1'b0, 32'hDEAD_BEEF};
        vecs[8] = '{1'b1, 1'b0, 32'h105, 32'h0,         3'b101, 1'b1, 32'h0};
        vecs[9] = '{1'b1, 1'b0, 32'h104, 32'h0,         3'b010, 1'b0, 32'h1122_3344};

        #2 rst = 1'b0;
        #1 check_zero("reset");
        repeat (3) @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 10; i++) do_txn(vecs[i]);

`ifdef ARB_ROUND_ROBIN_EN
        arb_exp = 3'b010;
`else
        arb_exp = 3'b111;
`endif
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h10;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h104; d_size = 3'b010;
        grants = 0; cyc = 0; last_g = 0;
        while (grants < 3 && cyc < 50) begin
            #1;
            chk1("arb_single_gnt", if_gnt & d_gnt, 1'b0);
            if (if_gnt || d_gnt) begin
                chk1("arb_winner_is_data", d_gnt, arb_exp[grants]);
                if (grants > 0) chk32("arb_spacing", 32'(cyc - last_g), 32'(WS + 2));
                last_g = cyc;
                grants++;
            end
            @(negedge clk);
            cyc++;
        end
        if_req = 1'b0; d_req = 1'b0;
        chk32("arb_grant_count", 32'(grants), 32'd3);
        repeat (WS + 3) @(negedge clk);
        #1;
`ifdef ARB_ROUND_ROBIN_EN
        chk32("arb_if_rdata", if_rdata, 32'h0050_0093);
`else
        chk32("arb_if_rdata", if_rdata, 32'h1122_3344);
`endif
        chk32("arb_d_rdata", d_rdata, 32'h1122_3344);

        @(negedge clk);
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h180; d_wdata = 32'hCAFE_F00D; d_size = 3'b010;
        #1 chk1("rst_gnt", d_gnt, 1'b1);
        @(negedge clk);
        d_req = 1'b0;
        #1 chk1("rst_busy_in_wait", busy, 1'b1);
        rst = 1'b0;
        #1 check_zero("abort");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < WS + 4; c++) begin
            @(negedge clk);
            #1 seen = seen | d_valid | mem_write_enable | busy;
        end
        chk1("abort_no_activity", seen, 1'b0);
        chk32("abort_no_write", 32'(wr_target), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
